// File: rtl/pc_next_ctrl.sv
// Next-PC generator and fetch sequencer (BOOT/RUN/HALT) with a saturating retired-instruction counter.
// Optional return-address stack is enabled by defining PC_RAS_EN.
module pc_next_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PCcur,
  input  logic              Branch,
  input  logic              Zero,
  input  logic [ADDR_W-1:0] BranchOff,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] JumpAddr,
  input  logic              Halt,
  input  logic              Resume,
  input  logic              Call,
  input  logic              Ret,
  output logic [ADDR_W-1:0] PCin,
  output logic              PCWrite,
  output logic              Halted,
  output logic [CNT_W-1:0]  InstrCount,
  output logic              RasErr
);

  typedef enum logic [1:0] {stBoot, stRun, stHalt} state_t;

  state_t            state, nextState;
  logic [ADDR_W-1:0] pcPlusOne, branchTarget, rasTop;
  logic              rasCall, rasRet, rasEmpty;
  logic              doPush, doPop, setErr;

  assign pcPlusOne    = PCcur + ADDR_W'(1);
  assign branchTarget = pcPlusOne + BranchOff;
  assign Halted       = (state == stHalt);

  always_ff @(posedge Clock) begin
    if (Reset) state <= stBoot;
    else       state <= nextState;
  end

  // Return/call outrank jumps and branches; halt outranks everything while running.
  always_comb begin
    nextState = state;
    PCin      = PCcur;
    PCWrite   = 1'b0;
    doPush    = 1'b0;
    doPop     = 1'b0;
    setErr    = 1'b0;
    if (Reset) begin
      PCin      = '0;
      nextState = stBoot;
    end else begin
      case (state)
        stBoot: nextState = stRun;
        stRun: begin
          if (Halt) begin
            nextState = stHalt;
          end else begin
            PCWrite = 1'b1;
            if (rasRet) begin
              if (rasEmpty) begin
                PCin   = pcPlusOne;
                setErr = 1'b1;
              end else begin
                PCin  = rasTop;
                doPop = 1'b1;
              end
            end else if (rasCall) begin
              PCin   = JumpAddr;
              doPush = 1'b1;
            end else if (Jump) begin
              PCin = JumpAddr;
            end else if (Branch && Zero) begin
              PCin = branchTarget;
            end else begin
              PCin = pcPlusOne;
            end
          end
        end
        stHalt: begin
          if (Resume) begin
            PCWrite   = 1'b1;
            PCin      = pcPlusOne;
            nextState = stRun;
          end
        end
        default: nextState = stBoot;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset)
      InstrCount <= '0;
    else if (state == stRun && PCWrite && InstrCount != '1)
      InstrCount <= InstrCount + CNT_W'(1);
  end

`ifdef PC_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int OCC_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] rasMem [RAS_DEPTH];
  logic [PTR_W-1:0]  rasPtr, topIdx, nextPtr;
  logic [OCC_W-1:0]  rasOcc;

  assign rasCall  = Call;
  assign rasRet   = Ret;
  assign rasEmpty = (rasOcc == '0);
  assign topIdx   = (rasPtr == '0) ? PTR_W'(RAS_DEPTH - 1) : rasPtr - PTR_W'(1);
  assign nextPtr  = (rasPtr == PTR_W'(RAS_DEPTH - 1)) ? '0 : rasPtr + PTR_W'(1);
  assign rasTop   = rasMem[topIdx];

  always_ff @(posedge Clock) begin
    if (!Reset && doPush) rasMem[rasPtr] <= pcPlusOne;
  end

  // Circular buffer: a push into a full stack silently overwrites the oldest entry.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rasPtr <= '0;
      rasOcc <= '0;
      RasErr <= 1'b0;
    end else begin
      if (doPush) begin
        rasPtr <= nextPtr;
        if (rasOcc != OCC_W'(RAS_DEPTH)) rasOcc <= rasOcc + OCC_W'(1);
      end else if (doPop) begin
        rasPtr <= topIdx;
        rasOcc <= rasOcc - OCC_W'(1);
      end
      if (setErr) RasErr <= 1'b1;
    end
  end
`else
  logic unusedRas;

  assign rasCall   = 1'b0;
  assign rasRet    = 1'b0;
  assign rasEmpty  = 1'b1;
  assign rasTop    = '0;
  assign RasErr    = 1'b0;
  assign unusedRas = ^{Call, Ret, doPush, doPop, setErr};
`endif

endmodule
